// File: rtl/snake_body_tracker.sv
// snake_body_tracker: snake segment ring buffer, occupancy bitmap, move/grow/restart FSM and tile queries
module snake_body_tracker #(
   parameter int GRID_W   = 40,
   parameter int GRID_H   = 30,
   parameter int MAXLEN   = 64,
   parameter int INIT_LEN = 3,
   parameter int START_X  = 20,
   parameter int START_Y  = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] writedata,
   input  logic       write,
   input  logic       chipselect,
   input  logic [2:0] address,
   input  logic [5:0] qx,
   input  logic [4:0] qy,
   output logic       q_occ,
   output logic       q_head,
   output logic [5:0] head_x,
   output logic [4:0] head_y,
   output logic [6:0] length,
   output logic       dead,
   output logic       busy
);
   localparam int PW = $clog2(MAXLEN);
   localparam logic [5:0] GW  = 6'(GRID_W);
   localparam logic [4:0] GH  = 5'(GRID_H);
   localparam logic [4:0] IL  = 5'(INIT_LEN);
   localparam logic [5:0] SX0 = 6'(START_X - INIT_LEN + 1);
   localparam logic [4:0] SY  = 5'(START_Y);
   localparam logic [6:0] ML  = 7'(MAXLEN);

   typedef enum logic [2:0] {S_CLR, S_SEG, S_IDLE, S_TAIL, S_CHECK, S_DEAD} state_t;
   state_t r_state, w_next;

   logic [GRID_W-1:0] r_map [GRID_H];
   logic [10:0]       r_buf [MAXLEN];
   logic [PW-1:0]     r_hp, r_tp;
   logic [6:0]        r_len;
   logic [4:0]        r_cnt, r_hy, r_ny;
   logic [5:0]        r_hx, r_nx;
   logic [1:0]        r_dir;
   logic              r_grow, r_q_occ, r_q_head;

   logic        w_wr, w_cmd, w_step, w_grow, w_restart, w_dir_ok, w_off, w_hit, w_grow_ok, w_qin;
   logic [5:0]  w_nx, w_seg_x, w_tx;
   logic [4:0]  w_ny, w_ty;
   logic        w_unused;

   assign w_wr      = chipselect & write;
   assign w_cmd     = w_wr & (address == 3'd1);
   assign w_step    = w_cmd & writedata[0];
   assign w_grow    = w_cmd & writedata[1];
   assign w_restart = w_cmd & writedata[2];
   assign w_unused  = &{1'b0, writedata[7:3]};
   // reversing direction flips bit 1 of the code
   assign w_dir_ok  = w_wr & (address == 3'd0) & (writedata[1:0] != (r_dir ^ 2'd2));
   assign w_nx      = (r_dir == 2'd0) ? r_hx + 6'd1 : (r_dir == 2'd2) ? r_hx - 6'd1 : r_hx;
   assign w_ny      = (r_dir == 2'd1) ? r_hy + 5'd1 : (r_dir == 2'd3) ? r_hy - 5'd1 : r_hy;
   assign w_off     = (r_dir == 2'd0 && r_hx == GW - 6'd1) | (r_dir == 2'd2 && r_hx == 6'd0) |
                      (r_dir == 2'd1 && r_hy == GH - 5'd1) | (r_dir == 2'd3 && r_hy == 5'd0);
   assign {w_tx, w_ty} = r_buf[r_tp];
   assign w_seg_x   = SX0 + {1'b0, r_cnt};
   assign w_grow_ok = r_grow && (r_len < ML);
   assign w_hit     = r_map[r_ny][r_nx];
   assign w_qin     = (qx < GW) && (qy < GH);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_CLR:   if (r_cnt == GH - 5'd1) w_next = S_SEG;
         S_SEG:   if (r_cnt == IL - 5'd1) w_next = S_IDLE;
         S_IDLE:  if (w_step) w_next = w_off ? S_DEAD : S_TAIL;
         S_TAIL:  w_next = S_CHECK;
         S_CHECK: w_next = w_hit ? S_DEAD : S_IDLE;
         default: w_next = r_state;
      endcase
      if (w_restart) w_next = S_CLR;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_CLR;
         r_cnt    <= '0;
         r_len    <= '0;
         r_grow   <= 1'b0;
         r_dir    <= 2'd0;
         r_hp     <= '0;
         r_tp     <= '0;
         r_hx     <= '0;
         r_hy     <= '0;
         r_nx     <= '0;
         r_ny     <= '0;
         r_q_occ  <= 1'b0;
         r_q_head <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_q_occ  <= w_qin ? r_map[qy][qx] : 1'b0;
         r_q_head <= w_qin ? (r_map[qy][qx] && qx == r_hx && qy == r_hy) : 1'b0;
         r_grow   <= w_grow | (r_grow & (r_state != S_TAIL));
         if (w_dir_ok) r_dir <= writedata[1:0];
         if (w_restart) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_grow <= 1'b0;
            r_dir  <= 2'd0;
            r_hp   <= '0;
            r_tp   <= '0;
         end else begin
            case (r_state)
               S_CLR: r_cnt <= (r_cnt == GH - 5'd1) ? 5'd0 : r_cnt + 5'd1;
               S_SEG: begin
                  r_cnt <= r_cnt + 5'd1;
                  r_len <= r_len + 7'd1;
                  r_hp  <= PW'(r_cnt);
                  r_hx  <= w_seg_x;
                  r_hy  <= SY;
               end
               S_IDLE: if (w_step) begin
                  r_nx <= w_nx;
                  r_ny <= w_ny;
               end
               S_TAIL: if (w_grow_ok) r_len <= r_len + 7'd1; else r_tp <= r_tp + PW'(1);
               S_CHECK: if (!w_hit) begin
                  r_hp <= r_hp + PW'(1);
                  r_hx <= r_nx;
                  r_hy <= r_ny;
               end
               default: ;
            endcase
         end
      end
   end

   // storage arrays are rebuilt by INIT_CLR/INIT_SEG, so they carry no reset
   always_ff @(posedge clk) begin
      if (r_state == S_CLR) r_map[r_cnt] <= '0;
      if (r_state == S_SEG) begin
         r_map[SY][w_seg_x]  <= 1'b1;
         r_buf[PW'(r_cnt)]   <= {w_seg_x, SY};
      end
      if (r_state == S_TAIL && !w_grow_ok) r_map[w_ty][w_tx] <= 1'b0;
      if (r_state == S_CHECK && !w_hit) begin
         r_map[r_ny][r_nx]       <= 1'b1;
         r_buf[r_hp + PW'(1)]    <= {r_nx, r_ny};
      end
   end

   assign q_occ  = r_q_occ;
   assign q_head = r_q_head;
   assign head_x = r_hx;
   assign head_y = r_hy;
   assign length = r_len;
   assign dead   = (r_state == S_DEAD);
   assign busy   = (r_state != S_IDLE) && (r_state != S_DEAD);
endmodule
